// File: rtl/hazard_controller_if.sv
// hazard_controller_if: ID-stage operands, EX/MEM status and pipeline controls for the hazard controller
//   slave  (controller): consumes ID/EX/MEM status, drives stall/flush/forward controls and counters
//   master (pipeline)  : drives ID/EX/MEM status, consumes the controls
interface hazard_controller_if #(parameter int XLEN_CNT = 16);
  logic                id_valid;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [4:0]          id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                ex_branch_taken;
  logic                dmem_busy;
  logic                pc_write_en;
  logic                ifid_write_en;
  logic                ifid_flush;
  logic                idex_bubble;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic [1:0]          ctrl_state;
  logic [XLEN_CNT-1:0] stall_cycles;
  logic [XLEN_CNT-1:0] flush_count;
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
    input  ex_branch_taken, dmem_busy,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, fwd_a, fwd_b, ctrl_state,
    output stall_cycles, flush_count
  );
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
    output ex_branch_taken, dmem_busy,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, fwd_a, fwd_b, ctrl_state,
    input  stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: 5-stage pipeline hazard unit (load-use stall, branch flush, dmem wait, forwarding)
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   hc    : slave modport carrying ID/EX/MEM status in and pipeline controls, forward selects,
//           action state and saturating stall/flush counters out
module hazard_controller #(parameter int XLEN_CNT = 16) (
  input logic               clk,
  input logic               rst_n,
  hazard_controller_if.slave hc
);
  localparam logic [1:0] S_RUN = 2'b00, S_STALL = 2'b01, S_FLUSH = 2'b10, S_WAIT = 2'b11;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ent_t;
  // r_sb[0]=EX, r_sb[1]=MEM, r_sb[2]=WB
  ent_t                r_sb [3];
  logic [1:0]          r_state, w_next;
  logic [1:0]          r_fa, r_fb, w_fa, w_fb;
  logic [XLEN_CNT-1:0] r_sc, r_fc;
  logic                w_src1, w_src2, w_lu;
  // A producer matches a source when it writes a nonzero rd equal to that live source index
  function automatic logic hit(input ent_t e, input logic [4:0] r, input logic s);
    return e.v & e.rw & (e.rd != 5'd0) & s & (e.rd == r);
  endfunction
  assign w_src1 = hc.id_valid & hc.id_use_rs1 & (hc.id_rs1 != 5'd0);
  assign w_src2 = hc.id_valid & hc.id_use_rs2 & (hc.id_rs2 != 5'd0);
  assign w_lu   = r_sb[0].mr & (hit(r_sb[0], hc.id_rs1, w_src1) | hit(r_sb[0], hc.id_rs2, w_src2));
  assign w_fa   = hit(r_sb[0], hc.id_rs1, w_src1) ? 2'b10 : hit(r_sb[1], hc.id_rs1, w_src1) ? 2'b01 : 2'b00;
  assign w_fb   = hit(r_sb[0], hc.id_rs2, w_src2) ? 2'b10 : hit(r_sb[1], hc.id_rs2, w_src2) ? 2'b01 : 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next;
  // A branch seen during a dmem wait is dropped; the datapath re-presents it afterwards
  always_comb
    w_next = hc.dmem_busy ? S_WAIT : (hc.ex_branch_taken & r_sb[0].v) ? S_FLUSH : w_lu ? S_STALL : S_RUN;
  always_comb begin
    hc.pc_write_en   = (w_next == S_RUN) | (w_next == S_FLUSH);
    hc.ifid_write_en = (w_next == S_RUN) | (w_next == S_FLUSH);
    hc.ifid_flush    = (w_next == S_FLUSH);
    hc.idex_bubble   = (w_next == S_STALL) | (w_next == S_FLUSH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sb[0] <= '0;
      r_sb[1] <= '0;
      r_sb[2] <= '0;
      r_fa    <= 2'b00;
      r_fb    <= 2'b00;
      r_sc    <= '0;
      r_fc    <= '0;
    end else begin
      if (w_next != S_WAIT) begin
        r_sb[2] <= r_sb[1];
        r_sb[1] <= r_sb[0];
        r_sb[0] <= (w_next == S_RUN && hc.id_valid) ? {1'b1, hc.id_rd, hc.id_reg_write, hc.id_mem_read} : '0;
        r_fa    <= (w_next == S_RUN) ? w_fa : 2'b00;
        r_fb    <= (w_next == S_RUN) ? w_fb : 2'b00;
      end
      if ((w_next == S_STALL || w_next == S_WAIT) && !(&r_sc)) r_sc <= r_sc + 1'b1;
      if (w_next == S_FLUSH && !(&r_fc)) r_fc <= r_fc + 1'b1;
    end
  assign hc.fwd_a        = r_fa;
  assign hc.fwd_b        = r_fb;
  assign hc.ctrl_state   = r_state;
  assign hc.stall_cycles = r_sc;
  assign hc.flush_count  = r_fc;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scoreboard bench for hazard_controller
module tb_hazard_controller;
  localparam logic [3:0] RUNC = 4'b1100, STALLC = 4'b0001, FLUSHC = 4'b1111, WAITC = 4'b0000;
  localparam logic [1:0] R = 2'b00, S = 2'b01, F = 2'b10, W = 2'b11;
  typedef struct {
    string       tag;
    logic [3:0]  ctl;
    logic [37:0] regs;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  hazard_controller_if hc ();
  hazard_controller dut (.clk(clk), .rst_n(rst_n), .hc(hc));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      logic [3:0]  actl;
      logic [37:0] aregs;
      e = q.pop_front();
      actl  = {hc.pc_write_en, hc.ifid_write_en, hc.ifid_flush, hc.idex_bubble};
      aregs = {hc.fwd_a, hc.fwd_b, hc.ctrl_state, hc.stall_cycles, hc.flush_count};
      checks++;
      if (actl !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl {pc,ifid_we,flush,bubble} got %b want %b", e.tag, actl, e.ctl);
      end
      checks++;
      if (aregs !== e.regs) begin
        errors++;
        $display("FAIL %s regs fa=%b fb=%b st=%b sc=%h fc=%h want fa=%b fb=%b st=%b sc=%h fc=%h", e.tag,
                 aregs[37:36], aregs[35:34], aregs[33:32], aregs[31:16], aregs[15:0],
                 e.regs[37:36], e.regs[35:34], e.regs[33:32], e.regs[31:16], e.regs[15:0]);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic br, input logic bz);
    hc.id_valid        = v;
    hc.id_rs1          = r1;
    hc.id_use_rs1      = u1;
    hc.id_rs2          = r2;
    hc.id_use_rs2      = u2;
    hc.id_rd           = rd;
    hc.id_reg_write    = rw;
    hc.id_mem_read     = mr;
    hc.ex_branch_taken = br;
    hc.dmem_busy       = bz;
  endtask
  task automatic chk(input string tag, input logic [3:0] c, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.tag  = tag;
    e.ctl  = c;
    e.regs = {fa, fb, st, sc, fc};
    q.push_back(e);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("rst_idle", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("rst_busy", WAITC, 0, 0, R, 16'h0, 16'h0);
    tick(); rst_n = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("release", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); chk("add_x5", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 5, 1, 3, 1, 6, 1, 0, 0, 0); chk("sub_x6", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("fwd_ex", RUNC, 2'b10, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); chk("add_x5b", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 1, 1, 2, 1, 8, 1, 0, 0, 0); chk("mid_x8", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 5, 1, 3, 1, 6, 1, 0, 0, 0); chk("sub_x6b", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("fwd_mem", RUNC, 2'b01, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); chk("ld_x7", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 2, 1, 7, 1, 9, 1, 0, 0, 0); chk("lu_stall", STALLC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(1, 2, 1, 7, 1, 9, 1, 0, 0, 0); chk("lu_release", RUNC, 0, 0, S, 16'h1, 16'h0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("lu_fwd_b", RUNC, 0, 2'b01, R, 16'h1, 16'h0);
    tick(); drv(1, 1, 1, 2, 1, 0, 0, 0, 0, 0); chk("branch", RUNC, 0, 0, R, 16'h1, 16'h0);
    tick(); drv(1, 3, 1, 4, 1, 10, 1, 0, 1, 0); chk("flush", FLUSHC, 0, 0, R, 16'h1, 16'h0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("post_flush", RUNC, 0, 0, F, 16'h1, 16'h1);
    tick(); drv(1, 1, 1, 2, 1, 0, 0, 0, 0, 0); chk("branch2", RUNC, 0, 0, R, 16'h1, 16'h1);
    tick(); drv(1, 3, 1, 4, 1, 11, 1, 0, 1, 1); chk("wait1", WAITC, 0, 0, R, 16'h1, 16'h1);
    tick(); drv(1, 3, 1, 4, 1, 11, 1, 0, 1, 1); chk("wait2", WAITC, 0, 0, W, 16'h2, 16'h1);
    tick(); drv(1, 3, 1, 4, 1, 11, 1, 0, 1, 1); chk("wait3", WAITC, 0, 0, W, 16'h3, 16'h1);
    tick(); drv(1, 3, 1, 4, 1, 11, 1, 0, 1, 0); chk("wait_flush", FLUSHC, 0, 0, W, 16'h4, 16'h1);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("post_wflush", RUNC, 0, 0, F, 16'h4, 16'h2);
    tick(); drv(1, 1, 1, 2, 1, 0, 1, 1, 0, 0); chk("ld_x0", RUNC, 0, 0, R, 16'h4, 16'h2);
    tick(); drv(1, 0, 1, 0, 1, 12, 1, 0, 0, 0); chk("rd_x0", RUNC, 0, 0, R, 16'h4, 16'h2);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("x0_fwd", RUNC, 0, 0, R, 16'h4, 16'h2);
    repeat (65530) begin
      tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("sat_pre", WAITC, 0, 0, W, 16'hFFFE, 16'h2);
    tick(); drv(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); chk("sat_ld", RUNC, 0, 0, W, 16'hFFFF, 16'h2);
    tick(); drv(1, 2, 1, 7, 1, 9, 1, 0, 0, 0); chk("sat_stall", STALLC, 0, 0, R, 16'hFFFF, 16'h2);
    tick(); drv(1, 2, 1, 7, 1, 9, 1, 0, 0, 0); chk("sat_hold", RUNC, 0, 0, S, 16'hFFFF, 16'h2);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("sat_fwd", RUNC, 0, 2'b01, R, 16'hFFFF, 16'h2);
    tick(); drv(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); chk("add_x5c", RUNC, 0, 0, R, 16'hFFFF, 16'h2);
    tick(); drv(1, 5, 1, 3, 1, 6, 1, 0, 0, 1); chk("wait_pre_rst", WAITC, 0, 0, R, 16'hFFFF, 16'h2);
    tick(); rst_n = 1'b0; drv(1, 5, 1, 3, 1, 6, 1, 0, 0, 1); chk("rst_in_wait", WAITC, 0, 0, R, 16'h0, 16'h0);
    tick(); rst_n = 1'b1; drv(1, 5, 1, 3, 1, 6, 1, 0, 0, 0); chk("rst_release", RUNC, 0, 0, R, 16'h0, 16'h0);
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("rst_dep_fwd", RUNC, 0, 0, R, 16'h0, 16'h0);
    repeat (5) if (q.size() != 0) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d entries left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
